// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman filter write-back controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package kf_pkg;

    // Write-port source select, chosen once per cycle by the arbiter
    typedef logic [2:0] src_t;

    localparam src_t SRC_NONE = 3'd0;
    localparam src_t SRC_COMB = 3'd1;
    localparam src_t SRC_FIFO = 3'd2;
    localparam src_t SRC_DIV  = 3'd3;
    localparam src_t SRC_EXT  = 3'd4;

    // Occupancy counter width: must be able to represent DEPTH itself
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/kf_wb_ctrl_if.sv
// Result/request bundle between the sequencer+AU side and the write-back controller.
// Latency: n/a (wiring only).
// Backpressure: none; the bank write port is fire-and-forget.
interface kf_wb_ctrl_if #(
    parameter int W     = 24,
    parameter int ADDRW = 5
);
    logic             seq_wr;
    logic [ADDRW-1:0] seq_addr;
    logic             comb_valid;
    logic [W-1:0]     comb_data;
    logic             div_done;
    logic [W-1:0]     div_data;
    logic             ready;
    logic             ext_write;
    logic [ADDRW-1:0] ext_dir;
    logic [W-1:0]     ext_data;
    logic             bank_we;
    logic [ADDRW-1:0] bank_addr;
    logic [W-1:0]     bank_data;

    // Sequencer/AU/external side: drives requests and results, observes the bank port
    modport master (
        output seq_wr, seq_addr, comb_valid, comb_data, div_done, div_data,
               ready, ext_write, ext_dir, ext_data,
        input  bank_we, bank_addr, bank_data
    );

    // Controller side
    modport slave (
        input  seq_wr, seq_addr, comb_valid, comb_data, div_done, div_data,
               ready, ext_write, ext_dir, ext_data,
        output bank_we, bank_addr, bank_data
    );
endinterface

// File: rtl/kf_wb_fifo.sv
// DEPTH x W synchronous FIFO for deferred AU results, with flush.
// Latency: push visible at head next cycle; head read combinationally.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module kf_wb_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [W-1:0]    wdata_i,
    output logic [W-1:0]    rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CNTW-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A simultaneous pop frees a slot, so a full FIFO can still accept
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign cnt_d   = cnt_q + CNTW'(push_ok) - CNTW'(pop_ok);

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/kf_wb_ctrl.sv
// Write-back controller: arbitrates AU/FIFO/divide/external results onto the Data Bank write port.
// Latency: 1 cycle from decision inputs to registered bank_we/addr/data; data_out one cycle later.
// Backpressure: none; full FIFO drops (err_ovf), starved seq_wr writes nothing (err_unf).
module kf_wb_ctrl
    import kf_pkg::*;
#(
    parameter int W     = 24,
    parameter int ADDRW = 5,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    kf_wb_ctrl_if.slave             bus,
    output logic [W-1:0]            data_out,
    output logic [cnt_w(DEPTH)-1:0] fifo_cnt,
    output logic                    div_pend,
    output logic                    err_ovf,
    output logic                    err_unf
);
    localparam int CNTW = cnt_w(DEPTH);

    src_t             src;
    logic             unf_evt;
    logic             push, pop, push_drop, div_ovf;
    logic [W-1:0]     fifo_rdata;
    logic             fifo_full, fifo_empty;

    logic             bank_we_q, bank_we_d;
    logic [ADDRW-1:0] bank_addr_q, bank_addr_d;
    logic [W-1:0]     bank_data_q, bank_data_d;
    logic [W-1:0]     data_out_q;
    logic             div_pend_q, div_pend_d;
    logic [W-1:0]     div_data_q, div_data_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;

    // Source arbitration: external path owns the port when the sequencer is idle,
    // otherwise seq_wr takes comb result, then oldest deferred result, then divide slot
    always_comb begin
        src     = SRC_NONE;
        unf_evt = 1'b0;
        if (bus.ready) begin
            if (bus.ext_write) src = SRC_EXT;
        end else if (bus.seq_wr) begin
            if (bus.comb_valid)   src = SRC_COMB;
            else if (!fifo_empty) src = SRC_FIFO;
            else if (div_pend_q)  src = SRC_DIV;
            else                  unf_evt = 1'b1;
        end
    end

    // A comb result not consumed directly by the sequencer is deferred
    assign push      = bus.comb_valid && !(bus.seq_wr && !bus.ready);
    assign pop       = (src == SRC_FIFO);
    assign push_drop = push && fifo_full && !pop;
    assign div_ovf   = bus.div_done && div_pend_q && (src != SRC_DIV);

    kf_wb_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.comb_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Next-state for the write port, divide slot and sticky error flags
    always_comb begin
        bank_we_d   = 1'b0;
        bank_addr_d = '0;
        bank_data_d = '0;
        case (src)
            SRC_EXT:  begin bank_we_d = 1'b1; bank_addr_d = bus.ext_dir;  bank_data_d = bus.ext_data;  end
            SRC_COMB: begin bank_we_d = 1'b1; bank_addr_d = bus.seq_addr; bank_data_d = bus.comb_data; end
            SRC_FIFO: begin bank_we_d = 1'b1; bank_addr_d = bus.seq_addr; bank_data_d = fifo_rdata;    end
            SRC_DIV:  begin bank_we_d = 1'b1; bank_addr_d = bus.seq_addr; bank_data_d = div_data_q;    end
            default:  ;
        endcase

        // New divide result wins over a same-cycle consume, keeping the slot full
        div_pend_d = div_pend_q;
        div_data_d = div_data_q;
        if (src == SRC_DIV) div_pend_d = 1'b0;
        if (bus.div_done) begin
            div_pend_d = 1'b1;
            div_data_d = bus.div_data;
        end

        err_ovf_d = err_ovf_q | push_drop | div_ovf;
        err_unf_d = err_unf_q | unf_evt;
    end

    // Registered write port, divide slot and error flags; clr flushes like reset
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bank_we_q   <= 1'b0;
            bank_addr_q <= '0;
            bank_data_q <= '0;
            div_pend_q  <= 1'b0;
            div_data_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            bank_we_q   <= bank_we_d;
            bank_addr_q <= bank_addr_d;
            bank_data_q <= bank_data_d;
            div_pend_q  <= div_pend_d;
            div_data_q  <= div_data_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

    // Last written value; survives clr so software can still read it back
    always_ff @(posedge clk) begin
        if (rst)                   data_out_q <= '0;
        else if (clr)              data_out_q <= data_out_q;
        else if (bank_we_q)        data_out_q <= bank_data_q;
    end

    assign bus.bank_we   = bank_we_q;
    assign bus.bank_addr = bank_addr_q;
    assign bus.bank_data = bank_data_q;
    assign data_out      = data_out_q;
    assign div_pend      = div_pend_q;
    assign err_ovf       = err_ovf_q;
    assign err_unf       = err_unf_q;
endmodule

// File: tb/tb_kf_wb_ctrl.sv
module tb_kf_wb_ctrl;
    localparam int W     = 24;
    localparam int ADDRW = 5;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst, clr;
    logic [W-1:0]    data_out;
    logic [CNTW-1:0] fifo_cnt;
    logic            div_pend, err_ovf, err_unf;

    always #5 clk = ~clk;

    kf_wb_ctrl_if #(.W(W), .ADDRW(ADDRW)) bus ();

    kf_wb_ctrl #(.W(W), .ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .bus      (bus),
        .data_out (data_out),
        .fifo_cnt (fifo_cnt),
        .div_pend (div_pend),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model state: deferred results as a plain queue, divide slot, flags,
    // and the write expected to appear on the bank port after the next edge
    logic [W-1:0]     mq[$];
    bit               m_pend;
    logic [W-1:0]     m_div;
    bit               m_ovf, m_unf, m_we;
    logic [ADDRW-1:0] m_addr;
    logic [W-1:0]     m_data, m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        rst = 1'b0; clr = 1'b0;
        bus.seq_wr = 1'b0; bus.seq_addr = '0;
        bus.comb_valid = 1'b0; bus.comb_data = '0;
        bus.div_done = 1'b0; bus.div_data = '0;
        bus.ready = 1'b0; bus.ext_write = 1'b0; bus.ext_dir = '0; bus.ext_data = '0;
    endtask

    // Apply the write-back rules to the inputs currently driven
    task automatic model_step();
        bit               push, nwe;
        logic [ADDRW-1:0] naddr;
        logic [W-1:0]     ndata;
        if (rst) begin
            mq.delete(); m_pend = 0; m_div = '0; m_ovf = 0; m_unf = 0;
            m_we = 0; m_addr = '0; m_data = '0; m_dout = '0;
        end else if (clr) begin
            mq.delete(); m_pend = 0; m_ovf = 0; m_unf = 0;
            m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            if (m_we) m_dout = m_data;
            nwe = 0; naddr = '0; ndata = '0;
            push = bus.comb_valid;
            if (bus.ready) begin
                if (bus.ext_write) begin nwe = 1; naddr = bus.ext_dir; ndata = bus.ext_data; end
            end else if (bus.seq_wr) begin
                push = 0;
                naddr = bus.seq_addr;
                if (bus.comb_valid)      begin nwe = 1; ndata = bus.comb_data; end
                else if (mq.size() > 0)  begin nwe = 1; ndata = mq.pop_front(); end
                else if (m_pend)         begin nwe = 1; ndata = m_div; m_pend = 0; end
                else                     m_unf = 1;
            end
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(bus.comb_data);
                else                   m_ovf = 1;
            end
            if (bus.div_done) begin
                if (m_pend) m_ovf = 1;
                m_pend = 1;
                m_div  = bus.div_data;
            end
            m_we = nwe; m_addr = naddr; m_data = ndata;
        end
    endtask

    // One clock: predict, advance, then compare every output against the model
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("bank_we", 32'(bus.bank_we), 32'(m_we));
        if (m_we) begin
            chk("bank_addr", 32'(bus.bank_addr), 32'(m_addr));
            chk("bank_data", 32'(bus.bank_data), 32'(m_data));
        end
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        chk("div_pend", 32'(div_pend), 32'(m_pend));
        chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
        chk("err_unf", 32'(err_unf), 32'(m_unf));
        chk("data_out", 32'(data_out), 32'(m_dout));
    endtask

    initial begin
        // Reset then idle
        idle_in(); rst = 1'b1; tick();
        idle_in(); tick();
        chk("rst_we", 32'(bus.bank_we), 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_errs", 32'({err_ovf, err_unf}), 32'd0);

        // Immediate comb write
        bus.seq_wr = 1'b1; bus.seq_addr = 5'd3; bus.comb_valid = 1'b1; bus.comb_data = 24'h004000;
        tick();
        chk("imm_we", 32'(bus.bank_we), 32'd1);
        chk("imm_addr", 32'(bus.bank_addr), 32'd3);
        chk("imm_data", 32'(bus.bank_data), 32'h004000);
        chk("imm_cnt", 32'(fifo_cnt), 32'd0);
        idle_in(); tick();
        chk("imm_dout", 32'(data_out), 32'h004000);

        // Deferred writes drain in order
        for (int i = 1; i <= 3; i++) begin
            idle_in(); bus.comb_valid = 1'b1; bus.comb_data = W'(i); tick();
        end
        chk("def_cnt3", 32'(fifo_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = ADDRW'(5 + i); tick();
            chk("def_data", 32'(bus.bank_data), 32'(i + 1));
        end
        chk("def_cnt0", 32'(fifo_cnt), 32'd0);

        // Overflow: the extra datum is dropped and never written
        for (int i = 0; i <= DEPTH; i++) begin
            idle_in(); bus.comb_valid = 1'b1; bus.comb_data = W'(8'h10 + i); tick();
        end
        chk("ovf_cnt", 32'(fifo_cnt), 32'(DEPTH));
        chk("ovf_flag", 32'(err_ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = 5'd1; tick();
        end
        chk("ovf_last", 32'(bus.bank_data), 32'(8'h10 + DEPTH - 1));
        for (int i = 0; i < 2; i++) begin
            idle_in(); bus.comb_valid = 1'b1; bus.comb_data = 24'hABC; tick();
        end
        idle_in(); clr = 1'b1; tick();
        chk("clr_cnt", 32'(fifo_cnt), 32'd0);
        chk("clr_ovf", 32'(err_ovf), 32'd0);

        // Divide path
        idle_in(); bus.div_done = 1'b1; bus.div_data = 24'h002000; tick();
        chk("div_pend1", 32'(div_pend), 32'd1);
        idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = 5'd9; tick();
        chk("div_addr", 32'(bus.bank_addr), 32'd9);
        chk("div_data", 32'(bus.bank_data), 32'h002000);
        chk("div_pend0", 32'(div_pend), 32'd0);
        idle_in(); bus.div_done = 1'b1; bus.div_data = 24'h003000; tick();
        idle_in(); bus.div_done = 1'b1; bus.div_data = 24'h003100; tick();
        chk("div_ovf", 32'(err_ovf), 32'd1);
        idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = 5'd10; tick();
        chk("div_latest", 32'(bus.bank_data), 32'h003100);

        // div_done while the slot is consumed: no overflow, slot stays full
        idle_in(); clr = 1'b1; tick();
        idle_in(); bus.div_done = 1'b1; bus.div_data = 24'h000111; tick();
        idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = 5'd2;
        bus.div_done = 1'b1; bus.div_data = 24'h000222; tick();
        chk("dcon_data", 32'(bus.bank_data), 32'h000111);
        chk("dcon_pend", 32'(div_pend), 32'd1);
        chk("dcon_ovf", 32'(err_ovf), 32'd0);
        idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = 5'd4; tick();
        chk("dcon_next", 32'(bus.bank_data), 32'h000222);

        // seq_wr + comb_valid + div_done together
        idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = 5'd6; bus.comb_valid = 1'b1;
        bus.comb_data = 24'h000333; bus.div_done = 1'b1; bus.div_data = 24'h000444; tick();
        chk("tri_data", 32'(bus.bank_data), 32'h000333);
        chk("tri_pend", 32'(div_pend), 32'd1);

        // External load; sequencer ignored, comb still captured
        idle_in(); bus.ready = 1'b1; bus.ext_write = 1'b1; bus.ext_dir = 5'd31; bus.ext_data = 24'hFFC000;
        bus.seq_wr = 1'b1; bus.seq_addr = 5'd7; tick();
        chk("ext_addr", 32'(bus.bank_addr), 32'd31);
        chk("ext_data", 32'(bus.bank_data), 32'hFFC000);
        idle_in(); bus.ready = 1'b1; bus.seq_wr = 1'b1; bus.comb_valid = 1'b1; bus.comb_data = 24'h555; tick();
        chk("ext_push", 32'(fifo_cnt), 32'd1);
        chk("ext_nowe", 32'(bus.bank_we), 32'd0);

        // Underflow on empty sources
        idle_in(); clr = 1'b1; tick();
        idle_in(); bus.seq_wr = 1'b1; bus.seq_addr = 5'd8; tick();
        chk("unf_we", 32'(bus.bank_we), 32'd0);
        chk("unf_flag", 32'(err_unf), 32'd1);

        // Divide result arriving right after reset is accepted
        idle_in(); rst = 1'b1; tick();
        idle_in(); bus.div_done = 1'b1; bus.div_data = 24'h000777; tick();
        chk("rdiv_pend", 32'(div_pend), 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 500; i++) begin
            idle_in();
            rst            = ($urandom_range(0, 149) == 0);
            clr            = ($urandom_range(0, 59) == 0);
            bus.ready      = ($urandom_range(0, 3) == 0);
            bus.seq_wr     = 1'($urandom_range(0, 1));
            bus.seq_addr   = ADDRW'($urandom);
            bus.comb_valid = ($urandom_range(0, 2) == 0);
            bus.comb_data  = W'($urandom);
            bus.div_done   = ($urandom_range(0, 4) == 0);
            bus.div_data   = W'($urandom);
            bus.ext_write  = 1'($urandom_range(0, 1));
            bus.ext_dir    = ADDRW'($urandom);
            bus.ext_data   = W'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
